vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_if.sv | 35 +++
 rtl/vga_delay_line.sv | 36 +++
 rtl/vga_timing_gen.sv | 157 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// ------------------------------------------------------------------
// vga_pkg : shared 640x480@60 timing constants, FSM states, helpers
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

package vga_pkg;

  localparam int c_cnt_w    = 10;
  localparam int c_h_active = 640;
  localparam int c_h_fp     = 16;
  localparam int c_h_sync   = 96;
  localparam int c_h_bp     = 48;
  localparam int c_v_active = 480;
  localparam int c_v_fp     = 10;
  localparam int c_v_sync   = 2;
  localparam int c_v_bp     = 33;

  typedef enum logic [0:0] {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } vga_state_e;

  // Half-open window test lo <= cnt < hi.
  function automatic logic in_window(input logic [c_cnt_w-1:0] cnt,
                                     input logic [c_cnt_w-1:0] lo,
                                     input logic [c_cnt_w-1:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_if.sv
// ------------------------------------------------------------------
// vga_if : pixel-fetch request/return and DAC pin bundle
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

interface vga_if;
  import vga_pkg::*;

  logic [c_cnt_w-1:0] px_x;
  logic [c_cnt_w-1:0] px_y;
  logic               px_req;
  logic [23:0]        rgb_in;
  logic [7:0]         vga_r;
  logic [7:0]         vga_g;
  logic [7:0]         vga_b;
  logic               vga_hs;
  logic               vga_vs;
  logic               vga_blank_n;
  logic               frame_start;

  modport master (
    output px_x, px_y, px_req, vga_r, vga_g, vga_b,
           vga_hs, vga_vs, vga_blank_n, frame_start,
    input  rgb_in
  );

  modport slave (
    input  px_x, px_y, px_req, vga_r, vga_g, vga_b,
           vga_hs, vga_vs, vga_blank_n, frame_start,
    output rgb_in
  );
endinterface

`default_nettype wire

// File: rtl/vga_delay_line.sv
// ------------------------------------------------------------------
// vga_delay_line : WIDTH x DEPTH shift register, flushable to IDLE
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module vga_delay_line #(
  parameter int               WIDTH = 3,
  parameter int               DEPTH = 1,
  parameter logic [WIDTH-1:0] IDLE  = '0
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             flush,
  input  wire logic [WIDTH-1:0] d,
  output logic      [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] r_stage;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_stage <= {DEPTH{IDLE}};
    end else begin
      r_stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign q = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ------------------------------------------------------------------
// vga_timing_gen : VGA raster counters, syncs and pixel-fetch alignment
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = c_h_active,
  parameter int H_FP     = c_h_fp,
  parameter int H_SYNC   = c_h_sync,
  parameter int H_BP     = c_h_bp,
  parameter int V_ACTIVE = c_v_active,
  parameter int V_FP     = c_v_fp,
  parameter int V_SYNC   = c_v_sync,
  parameter int V_BP     = c_v_bp,
  parameter int PIPE_DLY = 1
) (
  input  wire logic refclk,
  input  wire logic rst,
  input  wire logic locked,
  vga_if.master     vga
);

  localparam int c_h_len = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_len = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [c_cnt_w-1:0] c_h_last  = c_cnt_w'(c_h_len - 1);
  localparam logic [c_cnt_w-1:0] c_v_last  = c_cnt_w'(c_v_len - 1);
  localparam logic [c_cnt_w-1:0] c_h_vis   = c_cnt_w'(H_ACTIVE);
  localparam logic [c_cnt_w-1:0] c_v_vis   = c_cnt_w'(V_ACTIVE);
  localparam logic [c_cnt_w-1:0] c_hs_lo   = c_cnt_w'(H_ACTIVE + H_FP);
  localparam logic [c_cnt_w-1:0] c_hs_hi   = c_cnt_w'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [c_cnt_w-1:0] c_vs_lo   = c_cnt_w'(V_ACTIVE + V_FP);
  localparam logic [c_cnt_w-1:0] c_vs_hi   = c_cnt_w'(V_ACTIVE + V_FP + V_SYNC);

  logic               r_lock_meta;
  logic               r_lock_s;
  vga_state_e         r_state;
  vga_state_e         w_state_nxt;
  logic               w_run;
  logic               w_run_nxt;
  logic               w_frame_start;
  logic [c_cnt_w-1:0] r_hcnt;
  logic [c_cnt_w-1:0] r_vcnt;
  logic [c_cnt_w-1:0] w_hcnt_nxt;
  logic [c_cnt_w-1:0] w_vcnt_nxt;
  logic               r_px_req;
  logic               w_hs_raw;
  logic               w_vs_raw;
  logic [2:0]         w_dly_q;
  logic               r_hs;
  logic               r_vs;
  logic               r_blank_n;
  logic [23:0]        r_rgb;

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= locked;
      r_lock_s    <= r_lock_meta;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) r_state <= WAIT_LOCK;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_LOCK: if (r_lock_s)  w_state_nxt = RUN;
      RUN:       if (!r_lock_s) w_state_nxt = WAIT_LOCK;
      default:                  w_state_nxt = WAIT_LOCK;
    endcase
  end

  always_comb begin
    w_run         = (r_state == RUN);
    w_run_nxt     = (w_state_nxt == RUN);
    w_frame_start = w_run && (r_hcnt == '0) && (r_vcnt == '0);
  end

  // Counters only advance while staying in RUN, so entry and lock loss both land on 0/0.
  always_comb begin
    w_hcnt_nxt = '0;
    w_vcnt_nxt = '0;
    if (w_run && w_run_nxt) begin
      if (r_hcnt == c_h_last) begin
        w_vcnt_nxt = (r_vcnt == c_v_last) ? '0 : r_vcnt + 1'b1;
      end else begin
        w_hcnt_nxt = r_hcnt + 1'b1;
        w_vcnt_nxt = r_vcnt;
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_hcnt   <= '0;
      r_vcnt   <= '0;
      r_px_req <= 1'b0;
    end else begin
      r_hcnt   <= w_hcnt_nxt;
      r_vcnt   <= w_vcnt_nxt;
      r_px_req <= w_run_nxt && (w_hcnt_nxt < c_h_vis) && (w_vcnt_nxt < c_v_vis);
    end
  end

  assign w_hs_raw = !(w_run && in_window(r_hcnt, c_hs_lo, c_hs_hi));
  assign w_vs_raw = !(w_run && in_window(r_vcnt, c_vs_lo, c_vs_hi));

  // Flushing on the same edge that leaves RUN truncates any sync pulse in flight.
  vga_delay_line #(
    .WIDTH (3),
    .DEPTH (PIPE_DLY),
    .IDLE  (3'b110)
  ) u_delay (
    .clk   (refclk),
    .rst   (rst),
    .flush (!w_run_nxt),
    .d     ({w_hs_raw, w_vs_raw, r_px_req}),
    .q     (w_dly_q)
  );

  always_ff @(posedge refclk) begin
    if (rst || !w_run_nxt) begin
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
      r_rgb     <= '0;
    end else begin
      r_hs      <= w_dly_q[2];
      r_vs      <= w_dly_q[1];
      r_blank_n <= w_dly_q[0];
      r_rgb     <= w_dly_q[0] ? vga.rgb_in : 24'h0;
    end
  end

  assign vga.px_x        = r_hcnt;
  assign vga.px_y        = r_vcnt;
  assign vga.px_req      = r_px_req;
  assign vga.frame_start = w_frame_start;
  assign vga.vga_hs      = r_hs;
  assign vga.vga_vs      = r_vs;
  assign vga.vga_blank_n = r_blank_n;
  assign vga.vga_r       = r_rgb[23:16];
  assign vga.vga_g       = r_rgb[15:8];
  assign vga.vga_b       = r_rgb[7:0];

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ------------------------------------------------------------------
// tb_vga_timing_gen : directed checks of three vga_timing_gen configurations
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_vga_timing_gen;

  logic refclk;
  logic rst;
  logic locked;

  int n_vec  = 0;
  int n_err  = 0;
  int cur_k  = -1;

  vga_if bus1 ();
  vga_if bus3 ();
  vga_if buss ();

  vga_timing_gen #(.PIPE_DLY(1)) u_dut1 (
    .refclk (refclk), .rst (rst), .locked (locked), .vga (bus1)
  );

  vga_timing_gen #(.PIPE_DLY(3)) u_dut3 (
    .refclk (refclk), .rst (rst), .locked (locked), .vga (bus3)
  );

  // Shrunken raster: 16 pixels x 8 lines, so whole frames fit in a short run.
  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .PIPE_DLY (2)
  ) u_duts (
    .refclk (refclk), .rst (rst), .locked (locked), .vga (buss)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // Pixel sources: return {x,y,A5} for the address presented PIPE_DLY cycles earlier.
  logic [23:0] src1;
  logic [23:0] src3 [3];
  logic [23:0] srcs [2];

  always @(posedge refclk) begin
    src1    <= {bus1.px_x[7:0], bus1.px_y[7:0], 8'hA5};
    src3[0] <= {bus3.px_x[7:0], bus3.px_y[7:0], 8'hA5};
    src3[1] <= src3[0];
    src3[2] <= src3[1];
    srcs[0] <= {buss.px_x[7:0], buss.px_y[7:0], 8'hA5};
    srcs[1] <= srcs[0];
  end

  assign bus1.rgb_in = src1;
  assign bus3.rgb_in = src3[2];
  assign buss.rgb_in = srcs[1];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d: got 0x%0h, expected 0x%0h", tag, cur_k, obs, exp);
    end
  endtask

  // Expected {hs, vs, blank_n, rgb} at the pins, k cycles after entering RUN.
  function automatic logic [26:0] model_pins(input int k, input int d,
      input int ha, input int hfp, input int hsw, input int hbp,
      input int va, input int vfp, input int vsw, input int vbp);
    int t, ht, vt, h, v;
    logic hs, vs, bl;
    logic [23:0] rgb;
    t = k - d - 1;
    if (t < 0) return {1'b1, 1'b1, 1'b0, 24'h0};
    ht  = ha + hfp + hsw + hbp;
    vt  = va + vfp + vsw + vbp;
    h   = t % ht;
    v   = (t / ht) % vt;
    hs  = !((h >= ha + hfp) && (h < ha + hfp + hsw));
    vs  = !((v >= va + vfp) && (v < va + vfp + vsw));
    bl  = (h < ha) && (v < va);
    rgb = bl ? {8'(h), 8'(v), 8'hA5} : 24'h0;
    return {hs, vs, bl, rgb};
  endfunction

  task automatic check_inst(input string nm, input int k, input int d,
      input int ha, input int hfp, input int hsw, input int hbp,
      input int va, input int vfp, input int vsw, input int vbp,
      input logic [9:0] px, input logic [9:0] py, input logic req, input logic fs,
      input logic hs, input logic vs, input logic bl, input logic [23:0] rgb);
    int ht, vt, h, v;
    logic [26:0] e;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    h  = k % ht;
    v  = (k / ht) % vt;
    e  = model_pins(k, d, ha, hfp, hsw, hbp, va, vfp, vsw, vbp);
    check_val({nm, ".px_x"},   32'(px),  32'(h));
    check_val({nm, ".px_y"},   32'(py),  32'(v));
    check_val({nm, ".px_req"}, 32'(req), 32'((h < ha) && (v < va)));
    check_val({nm, ".fs"},     32'(fs),  32'((k % (ht * vt)) == 0));
    check_val({nm, ".hs"},     32'(hs),  32'(e[26]));
    check_val({nm, ".vs"},     32'(vs),  32'(e[25]));
    check_val({nm, ".blank"},  32'(bl),  32'(e[24]));
    check_val({nm, ".rgb"},    32'(rgb), 32'(e[23:0]));
  endtask

  task automatic check_all(input int k);
    check_inst("d1", k, 1, 640, 16, 96, 48, 480, 10, 2, 33,
      bus1.px_x, bus1.px_y, bus1.px_req, bus1.frame_start,
      bus1.vga_hs, bus1.vga_vs, bus1.vga_blank_n, {bus1.vga_r, bus1.vga_g, bus1.vga_b});
    check_inst("d3", k, 3, 640, 16, 96, 48, 480, 10, 2, 33,
      bus3.px_x, bus3.px_y, bus3.px_req, bus3.frame_start,
      bus3.vga_hs, bus3.vga_vs, bus3.vga_blank_n, {bus3.vga_r, bus3.vga_g, bus3.vga_b});
    check_inst("ds", k, 2, 8, 2, 3, 3, 4, 1, 2, 1,
      buss.px_x, buss.px_y, buss.px_req, buss.frame_start,
      buss.vga_hs, buss.vga_vs, buss.vga_blank_n, {buss.vga_r, buss.vga_g, buss.vga_b});
  endtask

  task automatic check_idle_one(input string nm, input logic [9:0] px, input logic [9:0] py,
      input logic req, input logic fs, input logic hs, input logic vs, input logic bl,
      input logic [23:0] rgb);
    check_val({nm, ".px_x"},   32'(px),  32'd0);
    check_val({nm, ".px_y"},   32'(py),  32'd0);
    check_val({nm, ".px_req"}, 32'(req), 32'd0);
    check_val({nm, ".fs"},     32'(fs),  32'd0);
    check_val({nm, ".hs"},     32'(hs),  32'd1);
    check_val({nm, ".vs"},     32'(vs),  32'd1);
    check_val({nm, ".blank"},  32'(bl),  32'd0);
    check_val({nm, ".rgb"},    32'(rgb), 32'd0);
  endtask

  task automatic check_idle_all(input string tag);
    check_idle_one({tag, ".d1"}, bus1.px_x, bus1.px_y, bus1.px_req, bus1.frame_start,
      bus1.vga_hs, bus1.vga_vs, bus1.vga_blank_n, {bus1.vga_r, bus1.vga_g, bus1.vga_b});
    check_idle_one({tag, ".d3"}, bus3.px_x, bus3.px_y, bus3.px_req, bus3.frame_start,
      bus3.vga_hs, bus3.vga_vs, bus3.vga_blank_n, {bus3.vga_r, bus3.vga_g, bus3.vga_b});
    check_idle_one({tag, ".ds"}, buss.px_x, buss.px_y, buss.px_req, buss.frame_start,
      buss.vga_hs, buss.vga_vs, buss.vga_blank_n, {buss.vga_r, buss.vga_g, buss.vga_b});
  endtask

  initial begin
    int   fall1, rise1, fall3, fallvs, risevs, nfs;
    logic prev_hs1, prev_hs3, prev_vss;

    rst    = 1'b1;
    locked = 1'b0;
    repeat (3) @(negedge refclk);
    check_idle_all("rst");

    // Lock present while reset is held must not start the raster.
    locked = 1'b1;
    repeat (3) @(negedge refclk);
    check_idle_all("rst_pri");

    rst = 1'b0;
    @(negedge refclk);
    check_val("fs_early1", 32'(bus1.frame_start), 32'd0);
    @(negedge refclk);
    check_val("fs_early2", 32'(bus1.frame_start), 32'd0);
    @(negedge refclk);

    fall1 = -1; rise1 = -1; fall3 = -1; fallvs = -1; risevs = -1; nfs = 0;
    prev_hs1 = 1'b1; prev_hs3 = 1'b1; prev_vss = 1'b1;
    for (int k = 0; k <= 1500; k++) begin
      cur_k = k;
      check_all(k);
      if (prev_hs1 && !bus1.vga_hs && fall1 < 0) fall1 = k;
      if (!prev_hs1 && bus1.vga_hs && fall1 >= 0 && rise1 < 0) rise1 = k;
      if (prev_hs3 && !bus3.vga_hs && fall3 < 0) fall3 = k;
      if (prev_vss && !buss.vga_vs && fallvs < 0) fallvs = k;
      if (!prev_vss && buss.vga_vs && fallvs >= 0 && risevs < 0) risevs = k;
      if (buss.frame_start) nfs++;
      prev_hs1 = bus1.vga_hs;
      prev_hs3 = bus3.vga_hs;
      prev_vss = buss.vga_vs;
      if (k < 1500) @(negedge refclk);
    end
    check_val("hs_fall_d1",  32'(fall1),          32'd658);
    check_val("hs_width_d1", 32'(rise1 - fall1),  32'd96);
    check_val("hs_fall_d3",  32'(fall3),          32'd660);
    check_val("vs_fall_ds",  32'(fallvs),         32'd83);
    check_val("vs_width_ds", 32'(risevs - fallvs), 32'd32);
    check_val("fs_count_ds", 32'(nfs),            32'd12);

    // Lock loss at h=700 of line 1, mid hsync pulse.
    locked = 1'b0;
    @(negedge refclk);
    cur_k = 1501;
    check_val("ll_px1", 32'(bus1.px_x), 32'd701);
    @(negedge refclk);
    cur_k = 1502;
    check_val("ll_px2", 32'(bus1.px_x), 32'd702);
    check_val("ll_hs2", 32'(bus1.vga_hs), 32'd0);
    @(negedge refclk);
    cur_k = 1503;
    check_idle_all("lockloss");
    repeat (4) @(negedge refclk);
    check_idle_all("waitlock");

    locked = 1'b1;
    @(negedge refclk);
    @(negedge refclk);
    check_val("relock_fs_early", 32'(bus1.frame_start), 32'd0);
    @(negedge refclk);

    for (int k = 0; k <= 1100; k++) begin
      cur_k = k;
      check_all(k);
      if (k < 1100) @(negedge refclk);
    end

    // Reset mid-frame (h=300, v=1 on the full-size raster) with lock still present.
    rst = 1'b1;
    @(negedge refclk);
    cur_k = -1;
    check_idle_all("midrst");
    repeat (2) @(negedge refclk);
    check_idle_all("rst_hold");

    rst = 1'b0;
    repeat (3) @(negedge refclk);
    cur_k = 0;
    check_all(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
